// File: rtl/vx_mem_responder_pkg.sv
// Shared defaults and helpers for the memory responder slice.
package vx_mem_responder_pkg;

  localparam int MR_DATA_SIZE  = 64;
  localparam int MR_ADDR_WIDTH = 10;
  localparam int MR_TAG_WIDTH  = 8;
  localparam int MR_RSP_DEPTH  = 4;

  // Width of a counter that must represent every value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vx_mem_responder_fifo.sv
// Response queue: registered storage, wrap-bit pointers, head shown combinationally
// so the outgoing response stays stable for as long as it is not popped.
module vx_mem_responder_fifo #(
  parameter string INSTANCE_ID = "",
  parameter int    DATAW       = 520,
  parameter int    DEPTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [DATAW-1:0] data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATAW-1:0] store [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign valid = ~empty;
  assign data  = store[rd_ptr[PTR_W-1:0]];

  // Pointer advance; reset empties the queue and discards anything held.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage carries no reset; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  // Credit accounting upstream must keep the queue from ever overflowing or underflowing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full)) else $error("%s: response queue overflow", INSTANCE_ID);
      assert (!(pop && empty)) else $error("%s: response queue underflow", INSTANCE_ID);
    end
  end

endmodule

// File: rtl/vx_mem_responder.sv
// Memory bus responder: byte-enabled single-port line memory with a registered
// read stage feeding an in-order response queue; credits bound acceptance so
// every accepted response-producing request always has a queue slot.
module vx_mem_responder import vx_mem_responder_pkg::*; #(
  parameter string INSTANCE_ID = "",
  parameter int    DATA_SIZE   = MR_DATA_SIZE,
  parameter int    ADDR_WIDTH  = MR_ADDR_WIDTH,
  parameter int    TAG_WIDTH   = MR_TAG_WIDTH,
  parameter int    RSP_DEPTH   = MR_RSP_DEPTH,
  parameter int    WRITE_ACK   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_SIZE*8-1:0] req_data,
  input  logic [DATA_SIZE-1:0]   req_byteen,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [DATA_SIZE*8-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic                   busy
);

  localparam int DATAW  = DATA_SIZE * 8;
  localparam int QW     = DATAW + TAG_WIDTH;
  localparam int CRED_W = count_width(RSP_DEPTH);
  localparam int LINES  = 1 << ADDR_WIDTH;

  logic [DATAW-1:0]     mem [LINES];
  logic [CRED_W-1:0]    credits;
  logic                 accept_p0;
  logic                 produce_p0;
  logic                 rsp_fire;
  logic                 vld_p1;
  logic                 wr_p1;
  logic [TAG_WIDTH-1:0] tag_p1;
  logic [DATAW-1:0]     rd_data_p1;
  logic [DATAW-1:0]     q_data_p1;
  logic [QW-1:0]        q_out;

  // Stage p0: acceptance and credit gating
  assign req_ready  = ~reset && (credits < CRED_W'(RSP_DEPTH));
  assign accept_p0  = req_valid && req_ready;
  assign produce_p0 = accept_p0 && (~req_rw || (WRITE_ACK != 0));
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign busy       = (credits != '0);

  // Credits count responses owed: in the read stage plus sitting in the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= '0;
    end else if (produce_p0 && !rsp_fire) begin
      credits <= credits + CRED_W'(1);
    end else if (!produce_p0 && rsp_fire) begin
      credits <= credits - CRED_W'(1);
    end
  end

  // Single-port line memory: byte-masked write or registered read, never cleared.
  always_ff @(posedge clk) begin
    if (accept_p0 && req_rw) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (req_byteen[i]) mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
      end
    end else if (accept_p0) begin
      rd_data_p1 <= mem[req_addr];
    end
  end

  // Stage p1: valid is control and resets; tag and kind ride along unreset.
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= produce_p0;
  end

  // Tag and request kind captured alongside the memory read.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      tag_p1 <= req_tag;
      wr_p1  <= req_rw;
    end
  end

  // Write acknowledgements carry zero data rather than stale read data.
  assign q_data_p1 = wr_p1 ? '0 : rd_data_p1;

  // Stage p2: response queue, head presented on the response port
  vx_mem_responder_fifo #(
    .INSTANCE_ID (INSTANCE_ID),
    .DATAW       (QW),
    .DEPTH       (RSP_DEPTH)
  ) rsp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data ({q_data_p1, tag_p1}),
    .pop       (rsp_fire),
    .valid     (rsp_valid),
    .data      (q_out)
  );

  assign rsp_data = q_out[QW-1:TAG_WIDTH];
  assign rsp_tag  = q_out[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_vx_mem_responder.sv
// Bench for vx_mem_responder: table of directed write/read records, directed
// multi-cycle sequences, and random traffic against a queue-based reference.
`timescale 1ns/1ps
module tb_vx_mem_responder;

  localparam int DS    = 64;
  localparam int AW    = 10;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = DS * 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_rw = 0, rsp_ready = 1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [DS-1:0] req_byteen = '0;
  logic [TW-1:0] req_tag = '0;
  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;

  logic          a_req_valid = 0, a_req_rw = 0, a_rsp_ready = 1;
  logic [AW-1:0] a_req_addr = '0;
  logic [DW-1:0] a_req_data = '0;
  logic [DS-1:0] a_req_byteen = '0;
  logic [TW-1:0] a_req_tag = '0;
  logic          a_req_ready, a_rsp_valid, a_busy;
  logic [DW-1:0] a_rsp_data;
  logic [TW-1:0] a_rsp_tag;

  vx_mem_responder #(.INSTANCE_ID("dut"), .DATA_SIZE(DS), .ADDR_WIDTH(AW),
    .TAG_WIDTH(TW), .RSP_DEPTH(DEPTH), .WRITE_ACK(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .req_byteen(req_byteen),
    .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready), .busy(busy));

  vx_mem_responder #(.INSTANCE_ID("dut_ack"), .DATA_SIZE(DS), .ADDR_WIDTH(AW),
    .TAG_WIDTH(TW), .RSP_DEPTH(DEPTH), .WRITE_ACK(1)) dut_ack (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_rw(a_req_rw),
    .req_addr(a_req_addr), .req_data(a_req_data), .req_byteen(a_req_byteen),
    .req_tag(a_req_tag), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag), .rsp_ready(a_rsp_ready), .busy(a_busy));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: memory image, owed responses in acceptance order with the
  // cycle at which each may first appear.
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            rdy;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  int            fire_cyc[$];
  int            cyc = 0;
  logic          rst_prev = 1'b1;
  logic          drv_use_exp = 1'b0;
  logic [DW-1:0] drv_exp = '0;

  initial forever begin
    exp_t e;
    logic exp_valid;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("ready_in_reset", req_ready, 0);
      if (rst_prev) begin
        chk("rsp_valid_in_reset", rsp_valid, 0);
        chk("busy_in_reset", busy, 0);
      end
      expq.delete();
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      exp_valid = (expq.size() > 0) && (expq[0].rdy <= cyc);
      chk("rsp_valid", rsp_valid, exp_valid);
      chk("req_ready", req_ready, expq.size() < DEPTH);
      chk("busy", busy, expq.size() != 0);
      if (rsp_valid && rsp_ready && expq.size() > 0) begin
        chk("rsp_tag", rsp_tag, expq[0].tag);
        chk("rsp_data", rsp_data, expq[0].data);
        void'(expq.pop_front());
        fire_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) begin
        if (req_rw) begin
          for (int i = 0; i < DS; i++)
            if (req_byteen[i]) mdl_mem[req_addr][i*8 +: 8] = req_data[i*8 +: 8];
        end else begin
          e.data = drv_use_exp ? drv_exp : mdl_mem[req_addr];
          e.tag  = req_tag;
          e.rdy  = cyc + 2;
          expq.push_back(e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [DS-1:0] be, input logic [TW-1:0] tag, input logic use_exp,
                      input logic [DW-1:0] exp, input int budget, output logic ok);
    req_valid = 1; req_rw = rw; req_addr = addr; req_data = data;
    req_byteen = be; req_tag = tag; drv_use_exp = use_exp; drv_exp = exp;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0; drv_use_exp = 0;
  endtask

  task automatic drain(input string name);
    rsp_ready = 1;
    for (int i = 0; i < 100 && expq.size() != 0; i++) idle(1);
    chk(name, expq.size(), 0);
    idle(2);
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DS-1:0] be;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[8];

  localparam logic [DW-1:0] LINE_A5 = {64{8'hA5}};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   n_acc;
    int   n0;
    logic [DW-1:0] rnd;

    vt[0] = '{1'b1, 10'h7, {64{8'hFF}}, {DS{1'b1}}, 8'h01, '0};
    vt[1] = '{1'b1, 10'h7, {{60{8'h00}}, 32'hDEADBEEF}, 64'h0F, 8'h02, '0};
    vt[2] = '{1'b1, 10'h5, LINE_A5, {DS{1'b1}}, 8'h11, '0};
    vt[3] = '{1'b0, 10'h5, '0, '0, 8'h22, LINE_A5};
    vt[4] = '{1'b0, 10'h7, '0, '0, 8'h23, {{60{8'hFF}}, 32'hDEADBEEF}};
    vt[5] = '{1'b1, 10'h9, {64{8'h3C}}, {DS{1'b1}}, 8'h30, '0};
    vt[6] = '{1'b1, 10'h9, {64{8'h77}}, {32{2'b10}}, 8'h31, '0};
    vt[7] = '{1'b0, 10'h9, '0, '0, 8'h32, {32{16'h773C}}};

    idle(3);
    reset = 0;
    idle(1);

    // Directed records, back to back
    foreach (vt[i]) begin
      send(vt[i].rw, vt[i].addr, vt[i].data, vt[i].be, vt[i].tag, 1'b1, vt[i].exp, 1, ok);
      chk("table_accept", ok, 1);
    end
    drain("table_drain");

    // Fill lines 16..31 for later reads
    for (int a = 16; a < 32; a++) begin
      for (int k = 0; k < DW / 32; k++) rnd[k*32 +: 32] = $urandom;
      send(1'b1, AW'(a), rnd, {DS{1'b1}}, 8'hF0, 1'b0, '0, 4, ok);
    end
    idle(2);

    // Backpressure: queue fills at four, fifth and sixth wait for a pop
    rsp_ready = 0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 10'h5, '0, '0, TW'(8'h40 + i), 1'b1, LINE_A5, 4, ok);
      n_acc += int'(ok);
    end
    chk("stall_accepts", n_acc, 4);
    send(1'b0, 10'h5, '0, '0, 8'h44, 1'b1, LINE_A5, 6, ok);
    chk("fifth_blocked", ok, 0);
    chk("ready_low_full", req_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_tag", rsp_tag, 8'h40);
      chk("stall_data", rsp_data, LINE_A5);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    send(1'b0, 10'h5, '0, '0, 8'h44, 1'b1, LINE_A5, 8, ok);
    chk("fifth_after_pop", ok, 1);
    send(1'b0, 10'h5, '0, '0, 8'h45, 1'b1, LINE_A5, 8, ok);
    chk("sixth_after_pop", ok, 1);
    drain("stall_drain");

    // Sixteen back-to-back reads at full throughput
    n0 = fire_cyc.size();
    n_acc = 0;
    for (int t = 0; t < 16; t++) begin
      send(1'b0, AW'(16 + t), '0, '0, TW'(t), 1'b0, '0, 1, ok);
      n_acc += int'(ok);
    end
    drain("burst_drain");
    chk("burst_accepts", n_acc, 16);
    chk("burst_count", fire_cyc.size() - n0, 16);
    if (fire_cyc.size() - n0 == 16)
      chk("burst_span", fire_cyc[n0 + 15] - fire_cyc[n0], 15);

    // Reset with reads pending: nothing emerges, memory survives
    rsp_ready = 0;
    for (int i = 0; i < 3; i++)
      send(1'b0, AW'(16 + i), '0, '0, TW'(8'h50 + i), 1'b0, '0, 4, ok);
    chk("busy_before_reset", busy, 1);
    reset = 1;
    idle(2);
    reset = 0;
    rsp_ready = 1;
    idle(5);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", rsp_valid, 0);
    send(1'b0, 10'h5, '0, '0, 8'h5A, 1'b1, LINE_A5, 2, ok);
    chk("post_reset_accept", ok, 1);
    drain("post_reset_drain");

    // Writes without acknowledgement produce nothing
    send(1'b1, 10'h28, {64{8'h12}}, {DS{1'b1}}, 8'h33, 1'b0, '0, 2, ok);
    repeat (3) begin
      @(negedge clk);
      chk("noack_busy", busy, 0);
      chk("noack_valid", rsp_valid, 0);
      @(posedge clk); #1;
    end

    // Write acknowledgement instance: zero-data response with the write tag
    a_req_valid = 1; a_req_rw = 1; a_req_addr = 10'h3;
    a_req_data = {64{8'h5E}}; a_req_byteen = {DS{1'b1}}; a_req_tag = 8'h33;
    @(negedge clk); chk("ack_ready", a_req_ready, 1);
    @(posedge clk); #1; a_req_valid = 0;
    @(negedge clk); chk("ack_busy_p1", a_busy, 1); chk("ack_valid_p1", a_rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("ack_valid", a_rsp_valid, 1);
    chk("ack_tag", a_rsp_tag, 8'h33); chk("ack_data", a_rsp_data, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("ack_valid_after", a_rsp_valid, 0); chk("ack_busy_after", a_busy, 0);
    @(posedge clk); #1;
    a_req_valid = 1; a_req_rw = 0; a_req_tag = 8'h34;
    @(negedge clk); chk("ack_rd_ready", a_req_ready, 1);
    @(posedge clk); #1; a_req_valid = 0;
    @(posedge clk); #1;
    @(negedge clk); chk("ack_rd_valid", a_rsp_valid, 1);
    chk("ack_rd_tag", a_rsp_tag, 8'h34); chk("ack_rd_data", a_rsp_data, {64{8'h5E}});
    @(posedge clk); #1;

    // Random traffic on lines 16..31 against the reference
    for (int c = 0; c < 400; c++) begin
      rsp_ready  = ($urandom_range(0, 9) < 7);
      req_valid  = $urandom_range(0, 1) == 1;
      req_rw     = $urandom_range(0, 2) == 0;
      req_addr   = AW'(16 + $urandom_range(0, 15));
      for (int k = 0; k < DW / 32; k++) req_data[k*32 +: 32] = $urandom;
      req_byteen = {$urandom, $urandom};
      req_tag    = TW'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 0;
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_mem_responder.md
VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", trace/instance string.
REQ-002 SHALL have parameter DATA_SIZE, default 64, line size in bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, line-address width; memory holds 2^ADDR_WIDTH lines.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, request tag width, echoed on response.
REQ-005 SHALL have parameter RSP_DEPTH, default 4, response queue depth (power of 2, >=2).
REQ-006 SHALL have parameter WRITE_ACK, default 0; 1 = writes also produce a response.
REQ-007 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have bus_if  VX_mem_bus_if.slave  (DATA_SIZE, ADDR_WIDTH, TAG_WIDTH)  memory bus responder end.
REQ-010 SHALL consume bus_if req_valid/req_data.{rw,addr,data,byteen,tag} and drive req_ready.
REQ-011 SHALL drive bus_if rsp_valid/rsp_data.{data,tag} and consume rsp_ready.
REQ-012 SHALL have busy  output  1  high while any accepted request has not yet produced its response.

Function
REQ-013 SHALL treat a request as accepted on a cycle with req_valid && req_ready.
REQ-014 SHALL keep a credit counter (width CLOG2(RSP_DEPTH+1)) = in-flight reads + queue occupancy.
REQ-015 SHALL assert req_ready = ~reset && (credits < RSP_DEPTH), regardless of rw.
REQ-016 SHALL increment credits on a response-producing accept, decrement on rsp fire, hold when both occur.
REQ-017 SHALL, on accepted write, update only bytes with byteen[i]=1 at the next edge; other bytes unchanged.
REQ-018 SHALL, on accepted read, read line addr through one SRAM register stage, then push {data,tag} into the response queue.
REQ-019 SHALL present the first response rsp_valid exactly 2 cycles after acceptance when the queue is empty and rsp_ready=1.
REQ-020 SHALL return responses in acceptance order; tag echoed unmodified.
REQ-021 SHALL give read-after-write on consecutive cycles (same addr) the newly written data.
REQ-022 SHALL, with WRITE_ACK=1, push a response for each write with the tag and rsp_data.data = 0.
REQ-023 SHALL hold rsp_valid and rsp_data stable while rsp_valid && ~rsp_ready.
REQ-024 SHALL sustain one accept and one response per cycle when rsp_ready=1 (full throughput).
REQ-025 SHALL, at credits == RSP_DEPTH, deassert req_ready; re-assert the cycle after an rsp fire.
REQ-026 SHALL never overflow the queue; overflow/underflow SHALL raise a simulation assertion.
REQ-027 SHALL derive busy = (credits != 0).

Reset
REQ-028 SHALL, on reset, clear credits, queue pointers and the SRAM valid stage; rsp_valid=0, req_ready=0, busy=0.
REQ-029 SHALL, on reset mid-operation, drop in-flight and queued responses without emitting them.
REQ-030 SHALL not initialise or clear memory contents on reset; contents survive reset.

Structure
REQ-031 SHALL use the shared mem bus request/response field widths from VX_gpu_pkg; no new package types.
REQ-032 SHALL implement the response queue with the existing VX_fifo_queue sub-module (DATAW = DATA_SIZE*8+TAG_WIDTH, DEPTH = RSP_DEPTH).
REQ-033 SHALL infer the memory as a single-port, byte-enabled synchronous RAM (VX_sp_ram).

Verification
REQ-034 Write addr 0x5 data 0xA5.. byteen all-1, tag 0x11; read addr 0x5 tag 0x22 next cycle -> rsp tag 0x22, data 0xA5.. at accept+2.
REQ-035 Write addr 0x7 byteen 0x0F (low 4 bytes 0xDEADBEEF) over line of 0xFF -> read returns low 4 bytes DEADBEEF, rest 0xFF.
REQ-036 rsp_ready=0, issue 6 reads (RSP_DEPTH=4) -> exactly 4 accepted, req_ready low; release rsp_ready -> tags in order, 2 remaining accepted.
REQ-037 Back-to-back 16 reads, rsp_ready=1 -> 16 responses on 16 consecutive cycles, in-order tags 0..15.
REQ-038 Assert reset with 3 reads pending -> no rsp_valid afterwards, busy=0; later read of addr 0x5 still returns 0xA5...
REQ-039 WRITE_ACK=1, write tag 0x33 -> one response tag 0x33, data 0; WRITE_ACK=0 -> no response, busy stays 0.
